coin_acceptor: RTL and testbench

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/coin_acceptor.sv | 124 ++++++++++++
 tb/tb_coin_acceptor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronizes and debounces five sensor inputs, queues
// coin/refund events, and issues one-cycle pulses with a guaranteed low gap between them.
module coin_acceptor #(
   parameter int DEBOUNCE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic nickel_sense,
   input  logic dime_sense,
   input  logic quarter_sense,
   input  logic dollar_sense,
   input  logic refund_sense,
   input  logic hold,
   output logic nickel,
   output logic dime,
   output logic quarter,
   output logic dollar,
   output logic refund,
   output logic busy,
   output logic overflow
);

   // state   | meaning
   // S_IDLE  | waiting for pending work with hold low
   // S_PULSE | one selected output high for this cycle
   // S_GAP   | mandatory low cycle after a pulse
   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

   localparam logic [2:0] DB_TC = 3'(DEBOUNCE);

   // Source index: 0 nickel, 1 dime, 2 quarter, 3 dollar, 4 refund
   logic [4:0]      w_raw;
   logic [4:0]      r_sync1, r_sync2, r_deb, r_deb_d;
   logic [4:0][2:0] r_cnt;
   logic [4:0]      w_event;
   logic [3:0][1:0] r_pend;
   logic            r_ref_pend;
   logic            r_ovf;
   logic [4:0]      r_out;
   logic [4:0]      w_sel;
   state_t          r_state, w_state_nxt;

   assign w_raw   = {refund_sense, dollar_sense, quarter_sense, dime_sense, nickel_sense};
   assign w_event = r_deb & ~r_deb_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         r_deb_d <= '0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_deb_d <= r_deb;
         for (int i = 0; i < 5; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] + 3'd1 == DB_TC) begin
               r_cnt[i] <= '0;
               r_deb[i] <= ~r_deb[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + 3'd1;
            end
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel       = '0;
      case (r_state)
         S_IDLE: begin
            if (!hold) begin
               if (r_pend[3] != 2'd0)      w_sel = 5'b01000;
               else if (r_pend[2] != 2'd0) w_sel = 5'b00100;
               else if (r_pend[1] != 2'd0) w_sel = 5'b00010;
               else if (r_pend[0] != 2'd0) w_sel = 5'b00001;
               else if (r_ref_pend)        w_sel = 5'b10000;
               if (w_sel != 5'b00000) w_state_nxt = S_PULSE;
            end
         end
         S_PULSE: w_state_nxt = S_GAP;
         S_GAP:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pending count consumed on the IDLE->PULSE edge; the pulse itself is registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_out      <= '0;
         r_pend     <= '0;
         r_ref_pend <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_out   <= w_sel;
         for (int i = 0; i < 4; i++) begin
            case ({w_event[i], w_sel[i]})
               2'b10: begin
                  if (r_pend[i] == 2'd3) r_ovf <= 1'b1;
                  else                   r_pend[i] <= r_pend[i] + 2'd1;
               end
               2'b01:   r_pend[i] <= r_pend[i] - 2'd1;
               default: ;
            endcase
         end
         if (w_event[4])    r_ref_pend <= 1'b1;
         else if (w_sel[4]) r_ref_pend <= 1'b0;
      end
   end

   assign nickel   = r_out[0];
   assign dime     = r_out[1];
   assign quarter  = r_out[2];
   assign dollar   = r_out[3];
   assign refund   = r_out[4];
   assign overflow = r_ovf;
   assign busy     = (|r_pend) | r_ref_pend | (r_state != S_IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios followed by random sensor/hold traffic,
// all checked every cycle against a cycle-level integer reference model.
module tb_coin_acceptor;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       hold;
   logic [4:0] sense;
   logic       nickel, dime, quarter, dollar, refund, busy, overflow;

   coin_acceptor #(.DEBOUNCE(D)) dut (
      .clk(clk), .reset(reset),
      .nickel_sense(sense[0]), .dime_sense(sense[1]), .quarter_sense(sense[2]),
      .dollar_sense(sense[3]), .refund_sense(sense[4]), .hold(hold),
      .nickel(nickel), .dime(dime), .quarter(quarter), .dollar(dollar), .refund(refund),
      .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: sensor history as run lengths, pending work as plain integers,
   // and pulse spacing expressed as "edges since the last issue".
   int       cyc = 0;
   bit [4:0] m_s1, m_s2, m_lvl, m_lvl_d;
   int       m_run [5];
   int       m_pend[5];
   int       m_last = -100;
   bit       m_ovf, m_busy;
   bit [4:0] m_out;
   int       order [5] = '{3, 2, 1, 0, 4};

   int       tcnt = 0;
   int       seen [5];
   int       first_q;
   int       q_order[$];

   task automatic model_step();
      bit [4:0] ev;
      int       pick;
      int       nv;
      if (reset) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_d = '0;
         for (int i = 0; i < 5; i++) begin m_run[i] = 0; m_pend[i] = 0; end
         m_last = -100; m_ovf = 0; m_out = '0; m_busy = 0;
      end else begin
         ev      = m_lvl & ~m_lvl_d;
         m_lvl_d = m_lvl;
         for (int i = 0; i < 5; i++) begin
            if (m_s2[i] != m_lvl[i]) begin
               m_run[i]++;
               if (m_run[i] == D) begin m_lvl[i] = ~m_lvl[i]; m_run[i] = 0; end
            end else m_run[i] = 0;
         end
         m_s2 = m_s1;
         m_s1 = sense;
         pick = -1;
         if (cyc - m_last >= 3 && !hold)
            foreach (order[k]) if (pick < 0 && m_pend[order[k]] > 0) pick = order[k];
         m_out = '0;
         if (pick >= 0) begin m_out[pick] = 1'b1; m_last = cyc; end
         m_busy = (cyc - m_last) < 2;
         for (int i = 0; i < 5; i++) begin
            nv = m_pend[i] + int'(ev[i]) - ((pick == i) ? 1 : 0);
            if (nv > ((i == 4) ? 1 : 3)) begin
               nv = (i == 4) ? 1 : 3;
               if (i != 4) m_ovf = 1;
            end
            m_pend[i] = nv;
            if (nv > 0) m_busy = 1;
         end
      end
      cyc++;
   endtask

   task automatic check_cycle();
      logic [4:0] outs;
      outs = {refund, dollar, quarter, dime, nickel};
      n_tests++;
      assert (outs === m_out) else begin
         n_fail++; $error("FAIL outs got=%b exp=%b t=%0t", outs, m_out, $time);
      end
      n_tests++;
      assert (busy === m_busy) else begin
         n_fail++; $error("FAIL busy got=%b exp=%b t=%0t", busy, m_busy, $time);
      end
      n_tests++;
      assert (overflow === m_ovf) else begin
         n_fail++; $error("FAIL overflow got=%b exp=%b t=%0t", overflow, m_ovf, $time);
      end
      n_tests++;
      assert ($onehot0(outs)) else begin
         n_fail++; $error("FAIL onehot got=%b exp=at-most-one t=%0t", outs, $time);
      end
      for (int i = 0; i < 5; i++) if (outs[i] === 1'b1) begin
         seen[i]++;
         q_order.push_back(i);
         if (i == 2 && first_q < 0) first_q = tcnt;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      tcnt++;
      check_cycle();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear_obs();
      for (int i = 0; i < 5; i++) seen[i] = 0;
      q_order.delete();
      first_q = -1;
      tcnt    = 0;
   endtask

   task automatic expect_int(input string tag, input int got, input int exp);
      n_tests++;
      assert (got == exp) else begin
         n_fail++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   initial begin
      int dur [5];
      int hdur;
      int found;
      reset = 1'b1; hold = 1'b0; sense = '0;
      clear_obs();
      @(negedge clk);
      ticks(3);
      expect_int("reset_busy", int'(busy), 0);
      expect_int("reset_ovf", int'(overflow), 0);
      reset = 1'b0;
      ticks(2);

      // clean quarter: pulse 7 cycles after the first sampling edge
      clear_obs();
      sense[2] = 1'b1;
      ticks(10);
      sense[2] = 1'b0;
      ticks(15);
      expect_int("q_count", seen[2], 1);
      expect_int("q_latency", first_q, D + 4);

      // short glitch below the debounce threshold
      clear_obs();
      sense[0] = 1'b1;
      ticks(3);
      sense[0] = 1'b0;
      ticks(15);
      expect_int("short_pulses", q_order.size(), 0);

      // bouncing dime
      clear_obs();
      sense[1] = 1'b1; tick(); sense[1] = 1'b0; tick();
      sense[1] = 1'b1; tick(); sense[1] = 1'b0; tick();
      sense[1] = 1'b1; ticks(10);
      sense[1] = 1'b0; ticks(15);
      expect_int("bounce_dime", seen[1], 1);
      expect_int("bounce_total", q_order.size(), 1);

      // simultaneous nickel, dollar and refund
      clear_obs();
      sense = 5'b11001;
      ticks(8);
      sense = '0;
      ticks(25);
      expect_int("order_len", q_order.size(), 3);
      if (q_order.size() == 3) begin
         expect_int("order0", q_order[0], 3);
         expect_int("order1", q_order[1], 0);
         expect_int("order2", q_order[2], 4);
      end

      // four nickels under hold saturate the counter
      clear_obs();
      hold = 1'b1;
      for (int n = 0; n < 4; n++) begin
         sense[0] = 1'b1; ticks(7);
         sense[0] = 1'b0; ticks(7);
      end
      ticks(4);
      expect_int("hold_nopulse", q_order.size(), 0);
      expect_int("hold_ovf", int'(overflow), 1);
      hold = 1'b0;
      ticks(20);
      expect_int("hold_nickels", seen[0], 3);

      // reset during quarter pulse with dime pending
      reset = 1'b1; ticks(2); reset = 1'b0; ticks(2);
      clear_obs();
      sense = 5'b00110;
      ticks(6);
      sense = '0;
      found = 0;
      for (int i = 0; i < 30 && found == 0; i++) begin
         tick();
         if (quarter === 1'b1) found = 1;
      end
      expect_int("rst_q_seen", found, 1);
      reset = 1'b1; tick(); reset = 1'b0;
      expect_int("rst_q_low", int'(quarter), 0);
      ticks(20);
      expect_int("rst_no_dime", seen[1], 0);
      expect_int("rst_busy", int'(busy), 0);
      expect_int("rst_ovf", int'(overflow), 0);

      // sensor held high across reset release yields one event
      clear_obs();
      sense[3] = 1'b1;
      reset = 1'b1; ticks(2); reset = 1'b0;
      ticks(12);
      sense[3] = 1'b0;
      ticks(12);
      expect_int("thru_reset", seen[3], 1);

      // random traffic
      for (int i = 0; i < 5; i++) dur[i] = 1;
      hdur = 1;
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 5; i++) begin
            dur[i]--;
            if (dur[i] <= 0) begin
               sense[i] = ~sense[i];
               dur[i]   = (sense[i]) ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 40));
            end
         end
         hdur--;
         if (hdur <= 0) begin
            hold = ~hold;
            hdur = (hold) ? int'($urandom_range(1, 30)) : int'($urandom_range(5, 80));
         end
         reset = ($urandom_range(0, 599) == 0);
         tick();
      end
      reset = 1'b0; hold = 1'b0; sense = '0;
      ticks(40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
